// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the read and write slaves: response codes,
// write-path FSM states and the bus data width.
package axil_pkg;

  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axil_regfile.sv
// Word-addressed register file with byte-enable write port, synchronous
// clear-to-zero and a combinational read port.
module axil_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axil_wr_slave.sv
// AXI-Lite write responder: captures AW and W independently, commits in one
// WRITE cycle, then holds B until accepted. Option: AXIL_WR_SLAVE_WSTRB_EN.
module axil_wr_slave
  import axil_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = AXIL_DATA_W
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [1:0]          s_axi_bresp,
  input  logic [3:0]          dbg_addr,
  output logic [DATA_W-1:0]   dbg_rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  wr_state_t             state, state_nxt;
  logic                  aw_held, w_held;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   wbe;
  resp_t                 bresp_q;
  logic                  aw_hs, w_hs, b_hs;
  logic                  addr_ok, commit;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign b_hs    = s_axi_bvalid && s_axi_bready;
  // Full-width compare so out-of-range addresses never alias onto a valid word.
  assign addr_ok = addr_q < ADDR_W'(DEPTH);
  assign commit  = (state == WRITE) && addr_ok;

`ifdef AXIL_WR_SLAVE_WSTRB_EN
  logic [DATA_W/8-1:0] strb_q;
  always_ff @(posedge s_axi_aclk) begin
    if (w_hs) strb_q <= s_axi_wstrb;
  end
  assign wbe = strb_q;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;
  assign wbe = '1;
`endif

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((aw_held || aw_hs) && (w_held || w_hs)) state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      bresp_q       <= RESP_OKAY;
    end else begin
      s_axi_awready <= (state == IDLE) && !aw_held && s_axi_awvalid && !s_axi_awready;
      s_axi_wready  <= (state == IDLE) && !w_held && s_axi_wvalid && !s_axi_wready;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (state == WRITE) begin
        s_axi_bvalid <= 1'b1;
        bresp_q      <= addr_ok ? RESP_OKAY : RESP_DECERR;
      end else if (b_hs) begin
        s_axi_bvalid <= 1'b0;
        bresp_q      <= RESP_OKAY;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (aw_hs) addr_q <= s_axi_awaddr;
    if (w_hs)  data_q <= s_axi_wdata;
  end

  assign s_axi_bresp = bresp_q;

  axil_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .we    (commit),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (data_q),
    .wbe   (wbe),
    .raddr (IDX_W'(dbg_addr)),
    .rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_axil_wr_slave.sv
// Directed bench for axil_wr_slave: B responses checked from a scoreboard queue,
// register contents checked against a reference word model.
module tb_axil_wr_slave;

  logic        clk;
  logic        areset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int n_chk = 0;
  int n_err = 0;
  logic [1:0]  exp_q [$];
  logic [31:0] model [16];

  axil_wr_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .dbg_addr      (dbg_addr),
    .dbg_rdata     (dbg_rdata)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
`ifdef AXIL_WR_SLAVE_WSTRB_EN
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
`else
    r = nw;
`endif
    return r;
  endfunction

  // Record the expected outcome of a write at the moment it is driven.
  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    if (addr < 32'd16) begin
      exp_q.push_back(2'b00);
      model[addr[3:0]] = merge(model[addr[3:0]], data, strb);
    end else begin
      exp_q.push_back(2'b11);
    end
  endtask

  task automatic pop_b(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {30'd0, bresp}, {30'd0, e});
    end
  endtask

  task automatic rd_chk(input string tag, input int idx);
    dbg_addr = idx[3:0];
    #1;
    chk(tag, dbg_rdata, model[idx]);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0];
      #1;
      chk($sformatf("%s[%0d]", tag, i), dbg_rdata, model[i]);
    end
  endtask

  // Present AW and W together; drop each valid after its own handshake edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    logic aw_go, w_go;
    expect_write(addr, data, strb);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      if (!awvalid && !wvalid) break;
    end
    chk("aw_w_timeout", {31'd0, awvalid | wvalid}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_bvalid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bvalid) break;
      step();
    end
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
  endtask

  // Wait for B, score it, then consume the handshake edge (bready must be 1).
  task automatic wait_b(input string tag);
    wait_bvalid(tag);
    if (bvalid) pop_b(tag);
    step();
  endtask

  initial begin
    areset = 1'b1; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
    wstrb = 4'hF; bready = 1'b1; dbg_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    step(); step();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    areset = 1'b0;
    step();
    check_mem("rst_mem");
    step();

    // 1: simultaneous AW/W, cycle-accurate latency
    expect_write(32'd3, 32'hDEAD_BEEF, 4'hF);
    awaddr = 32'd3; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1;
    chk("t1_awready_c0", {31'd0, awready}, 32'd0);
    step();
    chk("t1_awready_c1", {31'd0, awready}, 32'd1);
    chk("t1_wready_c1",  {31'd0, wready},  32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_awready_c2", {31'd0, awready}, 32'd0);
    chk("t1_wready_c2",  {31'd0, wready},  32'd0);
    chk("t1_bvalid_c2",  {31'd0, bvalid},  32'd0);
    step();
    chk("t1_bvalid_c3", {31'd0, bvalid}, 32'd1);
    pop_b("t1_bresp");
    rd_chk("t1_mem3", 3);
    step();
    chk("t1_bvalid_c4", {31'd0, bvalid}, 32'd0);
    chk("t1_bresp_c4",  {30'd0, bresp},  32'd0);

    // 2: W leads AW by five cycles
    expect_write(32'd7, 32'h1234_5678, 4'hF);
    wdata = 32'h1234_5678; wvalid = 1'b1;
    step();
    chk("t2_wready",    {31'd0, wready},  32'd1);
    chk("t2_awready_w", {31'd0, awready}, 32'd0);
    step();
    wvalid = 1'b0;
    chk("t2_wready_drop", {31'd0, wready}, 32'd0);
    step(); step(); step();
    awaddr = 32'd7; awvalid = 1'b1;
    step();
    chk("t2_awready", {31'd0, awready}, 32'd1);
    chk("t2_wready_aw", {31'd0, wready}, 32'd0);
    step();
    awvalid = 1'b0;
    chk("t2_bvalid_early", {31'd0, bvalid}, 32'd0);
    step();
    chk("t2_bvalid", {31'd0, bvalid}, 32'd1);
    pop_b("t2_bresp");
    rd_chk("t2_mem7", 7);
    step();

    // 3: out-of-range addresses and the top legal word
    do_write(32'd16, 32'hFFFF_FFFF, 4'hF);
    wait_b("t3_addr16");
    do_write(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    wait_b("t3_addrmax");
    check_mem("t3_mem");
    step();
    do_write(32'd15, 32'hCAFE_F00D, 4'hF);
    wait_b("t3_addr15");
    rd_chk("t3_mem15", 15);
    step();

    // 4: B backpressure with a second write waiting
    bready = 1'b0;
    do_write(32'd5, 32'hA5A5_A5A5, 4'hF);
    wait_bvalid("t4_first");
    awaddr = 32'd6; wdata = 32'h0BAD_CAFE; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_bvalid_hold%0d", i),  {31'd0, bvalid},  32'd1);
      chk($sformatf("t4_bresp_hold%0d", i),   {30'd0, bresp},   32'd0);
      chk($sformatf("t4_awready_hold%0d", i), {31'd0, awready}, 32'd0);
      chk($sformatf("t4_wready_hold%0d", i),  {31'd0, wready},  32'd0);
    end
    bready = 1'b1;
    pop_b("t4_first_bresp");
    step();
    chk("t4_bvalid_done", {31'd0, bvalid}, 32'd0);
    do_write(32'd6, 32'h0BAD_CAFE, 4'hF);
    wait_b("t4_second");
    rd_chk("t4_mem5", 5);
    rd_chk("t4_mem6", 6);
    step();

    // 5: byte strobes
    do_write(32'd2, 32'hAABB_CCDD, 4'hF);
    wait_b("t5_base");
    do_write(32'd2, 32'h1122_3344, 4'b0101);
    wait_b("t5_strb");
    dbg_addr = 4'd2;
    #1;
`ifdef AXIL_WR_SLAVE_WSTRB_EN
    chk("t5_mem2_const", dbg_rdata, 32'hAA22_CC44);
`else
    chk("t5_mem2_const", dbg_rdata, 32'h1122_3344);
`endif
    do_write(32'd2, 32'h5566_7788, 4'b0000);
    wait_b("t5_strb0");
    rd_chk("t5_mem2_zero_strb", 2);
    step();

    // 6: reset while B is pending
    bready = 1'b0;
    do_write(32'd9, 32'h9999_0000, 4'hF);
    wait_bvalid("t6_pre");
    areset = 1'b1;
    step();
    chk("t6_bvalid",  {31'd0, bvalid},  32'd0);
    chk("t6_awready", {31'd0, awready}, 32'd0);
    chk("t6_wready",  {31'd0, wready},  32'd0);
    areset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    check_mem("t6_mem");
    bready = 1'b1;
    step();
    do_write(32'd1, 32'h0000_0042, 4'hF);
    wait_b("t6_after");
    rd_chk("t6_mem1", 1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
